// File: rtl/sram_march_bist_if.sv
// sram_march_bist_if -- single-port (RW) SRAM macro port bundle.
//
// Signals:
//   csb0   active-low chip select      (BIST -> SRAM)
//   web0   active-low write enable     (BIST -> SRAM)
//   addr0  word address                (BIST -> SRAM)
//   din0   write data                  (BIST -> SRAM)
//   dout0  read data                   (SRAM -> BIST)
//
// Modports:
//   master  BIST controller side
//   slave   SRAM macro side
interface sram_march_bist_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        output csb0,
        output web0,
        output addr0,
        output din0,
        input  dout0
    );

    modport slave (
        input  csb0,
        input  web0,
        input  addr0,
        input  din0,
        output dout0
    );
endinterface

// File: rtl/sram_march_bist.sv
// sram_march_bist -- March C- built-in self-test controller for one
// single-port SRAM macro port. One memory operation per cycle, 10N ops
// per background, reads compared two edges after presentation.
//
// Ports:
//   clk0             clock, shared with the SRAM port
//   rst0             synchronous active-high reset
//   start            begin a test (ignored while busy)
//   busy             test in progress
//   done             test finished; held until next start or reset
//   pass             valid with done; 1 = no mismatches
//   fail_count       saturating mismatch count
//   first_fail_addr  address of the first mismatch
//   first_fail_elem  March element (0-5) of the first mismatch
//   sram             SRAM port (csb0/web0/addr0/din0 out, dout0 in)
//
// Optional build macro:
//   SRAM_BIST_CHECKERBOARD_EN  repeat the 10N sequence with a checkerboard
//                              background (01.. pattern, inverted on odd
//                              addresses) after the solid pass.
module sram_march_bist #(
    parameter int DATA_WIDTH     = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk0,
    input  logic                      rst0,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr,
    output logic [2:0]                first_fail_elem,
    sram_march_bist_if.master         sram
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0]     ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = 1;
    localparam logic [FAIL_CNT_WIDTH-1:0] FAIL_ONE = 1;

    state_t state;

    // Sequencer position: the op that will be presented at the next edge.
    logic [2:0]            elem;
    logic                  step;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cb;
    logic                  flush_cnt;

    // Two-stage compare pipeline aligned to the SRAM read latency.
    logic                  p1_valid, p2_valid;
    logic [DATA_WIDTH-1:0] p1_exp, p2_exp;
    logic [ADDR_WIDTH-1:0] p1_addr, p2_addr;
    logic [2:0]            p1_elem, p2_elem;

    // Decoded current op and next sequencer position.
    logic                  op_read, op_inv, op_last;
    logic [DATA_WIDTH-1:0] bg, op_data;
    logic [2:0]            nx_elem;
    logic                  nx_step;
    logic [ADDR_WIDTH-1:0] nx_addr;
    logic                  nx_cb;

    always_comb begin
        bg = '0;
`ifdef SRAM_BIST_CHECKERBOARD_EN
        if (cb) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                bg[i] = (i[0] == addr[0]);
            end
        end
`endif
        // E0: w0 | E1,E3: r0 w1 | E2,E4: r1 w0 | E5: r0
        op_read = 1'b0;
        op_inv  = 1'b0;
        case (elem)
            3'd0: begin
                op_read = 1'b0;
                op_inv  = 1'b0;
            end
            3'd1, 3'd3: begin
                op_read = ~step;
                op_inv  = step;
            end
            3'd2, 3'd4: begin
                op_read = ~step;
                op_inv  = ~step;
            end
            default: begin
                op_read = 1'b1;
                op_inv  = 1'b0;
            end
        endcase
        op_data = op_inv ? ~bg : bg;

        nx_elem = elem;
        nx_step = step;
        nx_addr = addr;
        nx_cb   = cb;
        op_last = 1'b0;
        if ((elem >= 3'd1) && (elem <= 3'd4) && !step) begin
            nx_step = 1'b1;
        end else begin
            nx_step = 1'b0;
            if ((elem == 3'd3) || (elem == 3'd4)) begin
                if (addr != '0) begin
                    nx_addr = addr - ADDR_ONE;
                end else begin
                    nx_elem = elem + 3'd1;
                    nx_addr = (elem == 3'd3) ? ADDR_MAX : '0;
                end
            end else if (addr != ADDR_MAX) begin
                nx_addr = addr + ADDR_ONE;
            end else if (elem == 3'd5) begin
                nx_elem = 3'd0;
                nx_addr = '0;
`ifdef SRAM_BIST_CHECKERBOARD_EN
                nx_cb   = 1'b1;
                op_last = cb;
`else
                op_last = 1'b1;
`endif
            end else begin
                nx_elem = elem + 3'd1;
                // E2 (up) is followed by the first down sweep.
                nx_addr = (elem == 3'd2) ? ADDR_MAX : '0;
            end
        end
    end

    logic                      mismatch;
    logic [FAIL_CNT_WIDTH-1:0] fail_next;
    logic                      present;

    always_comb begin
        mismatch  = p2_valid && (sram.dout0 != p2_exp);
        fail_next = fail_count;
        if (mismatch && (fail_count != '1)) begin
            fail_next = fail_count + FAIL_ONE;
        end
        present = (state == RUN) ||
                  (((state == IDLE) || (state == DONE)) && start);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            sram.csb0       <= 1'b1;
            sram.web0       <= 1'b1;
            sram.addr0      <= '0;
            sram.din0       <= '0;
            elem            <= '0;
            step            <= 1'b0;
            addr            <= '0;
            cb              <= 1'b0;
            flush_cnt       <= 1'b0;
            p1_valid        <= 1'b0;
            p2_valid        <= 1'b0;
            p1_exp          <= '0;
            p2_exp          <= '0;
            p1_addr         <= '0;
            p2_addr         <= '0;
            p1_elem         <= '0;
            p2_elem         <= '0;
        end else begin
            // Compare stage runs in every state so reads drain during FLUSH.
            p2_valid   <= p1_valid;
            p2_exp     <= p1_exp;
            p2_addr    <= p1_addr;
            p2_elem    <= p1_elem;
            fail_count <= fail_next;
            if (mismatch && (fail_count == '0)) begin
                first_fail_addr <= p2_addr;
                first_fail_elem <= p2_elem;
            end

            p1_valid <= 1'b0;
            if (present) begin
                sram.csb0  <= 1'b0;
                sram.web0  <= op_read;
                sram.addr0 <= addr;
                sram.din0  <= op_data;
                p1_valid   <= op_read;
                p1_exp     <= op_data;
                p1_addr    <= addr;
                p1_elem    <= elem;
                if (op_last) begin
                    elem <= '0;
                    step <= 1'b0;
                    addr <= '0;
                    cb   <= 1'b0;
                end else begin
                    elem <= nx_elem;
                    step <= nx_step;
                    addr <= nx_addr;
                    cb   <= nx_cb;
                end
            end else begin
                sram.csb0  <= 1'b1;
                sram.web0  <= 1'b1;
                sram.addr0 <= '0;
                sram.din0  <= '0;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                        first_fail_elem <= '0;
                        flush_cnt       <= 1'b0;
                    end
                end
                RUN: begin
                    if (op_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Second FLUSH edge is the compare of the final read.
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist -- directed self-checking bench for sram_march_bist.
// DUT 1 drives a behavioural SRAM with an optional stuck-at-1 fault on
// bit0 of word 5; DUT 2 (FAIL_CNT_WIDTH=2) sees dout0 tied to zero.
// Honours SRAM_BIST_CHECKERBOARD_EN (doubles the op count).
module tb_sram_march_bist;
    localparam int DW = 2;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef SRAM_BIST_CHECKERBOARD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int OPS         = 10 * N * PASSES;
    localparam int FAULT_FAILS = 3 * PASSES;

    logic clk0 = 1'b0;
    logic rst0;
    logic start;
    always #5 clk0 = ~clk0;

    logic          busy, done, pass;
    logic [7:0]    fail_count;
    logic [AW-1:0] first_fail_addr;
    logic [2:0]    first_fail_elem;

    logic          busy2, done2, pass2;
    logic [1:0]    fail_count2;
    logic [AW-1:0] first_fail_addr2;
    logic [2:0]    first_fail_elem2;

    sram_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();
    sram_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif2 ();

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FAIL_CNT_WIDTH(8)) dut (
        .clk0(clk0), .rst0(rst0), .start(start),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr), .first_fail_elem(first_fail_elem),
        .sram(sif.master)
    );

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FAIL_CNT_WIDTH(2)) dut2 (
        .clk0(clk0), .rst0(rst0), .start(start),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
        .first_fail_addr(first_fail_addr2), .first_fail_elem(first_fail_elem2),
        .sram(sif2.master)
    );

    assign sif2.dout0 = '0;

    // Behavioural single-port SRAM, one-cycle read latency.
    logic [DW-1:0] mem [N];
    logic          fault_en = 1'b0;
    always @(posedge clk0) begin
        if (!sif.csb0) begin
            if (!sif.web0) mem[sif.addr0] <= sif.din0;
            else sif.dout0 <= mem[sif.addr0] |
                              ((fault_en && sif.addr0 == 4'd5) ? 2'b01 : 2'b00);
        end
    end

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected op c (0-based from start edge), written independently of the RTL.
    function automatic bit op_ok(input int c, input logic web, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        int k, e, idx, ea;
        bit rd;
        logic [DW-1:0] bgv, wd;
        k = c % (10 * N);
        if (k < N) begin
            e = 0; idx = k; rd = 1'b0;
        end else if (k < 9 * N) begin
            e   = 1 + (k - N) / (2 * N);
            idx = ((k - N) % (2 * N)) / 2;
            rd  = ((k - N) % 2) == 0;
        end else begin
            e = 5; idx = k - 9 * N; rd = 1'b1;
        end
        ea = (e == 3 || e == 4) ? (N - 1 - idx) : idx;
        if (c >= 10 * N) bgv = (ea % 2 == 0) ? 2'b01 : 2'b10;
        else bgv = 2'b00;
        wd = (e == 1 || e == 3) ? ~bgv : bgv;
        return (int'(a) == ea) && (web == rd) && (rd || d == wd);
    endfunction

    int s_cyc = 0;
    bit mon = 1'b0;
    int low_in, low_out, op_err;
    always @(negedge clk0) begin
        int c;
        if (mon && !sif.csb0) begin
            c = cyc - s_cyc;
            if (c >= 0 && c < OPS) begin
                low_in++;
                if (!op_ok(c, sif.web0, sif.addr0, sif.din0)) op_err++;
            end else begin
                low_out++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        check({tag, "_ffa"}, first_fail_addr, 0);
        check({tag, "_ffe"}, first_fail_elem, 0);
        check({tag, "_csb0"}, sif.csb0, 1);
        check({tag, "_web0"}, sif.web0, 1);
        check({tag, "_addr0"}, sif.addr0, 0);
        check({tag, "_din0"}, sif.din0, 0);
    endtask

    // Pulses (or holds) start; returns just after edge S with monitors armed.
    task automatic run_start(input bit hold);
        @(negedge clk0);
        start = 1'b1;
        @(posedge clk0);
        #1;
        s_cyc   = cyc;
        low_in  = 0;
        low_out = 0;
        op_err  = 0;
        mon     = 1'b1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < OPS + 20; i++) begin
            @(posedge clk0);
            #1;
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_done_latency"}, cyc - s_cyc, OPS + 1);
    endtask

    initial begin
        rst0  = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        check_reset_state("reset");
        rst0 = 1'b0;

        // Run 1: fault-free; DUT 2 sees all-zero reads.
        run_start(1'b0);
        check("r1_S_busy", busy, 1);
        check("r1_S_csb0", sif.csb0, 0);
        check("r1_S_web0", sif.web0, 0);
        check("r1_S_addr0", sif.addr0, 0);
        wait_done("r1");
        check("r1_pass", pass, 1);
        check("r1_fail_count", fail_count, 0);
        check("r1_busy", busy, 0);
        check("r1_done2", done2, 1);
        check("r1_pass2", pass2, 0);
        check("r1_fail_count2_sat", fail_count2, 3);
        check("r1_ffa2", first_fail_addr2, 0);
        check("r1_ffe2", first_fail_elem2, 2);
        repeat (3) @(posedge clk0);
        #1;
        check("r1_csb_low_cycles", low_in, OPS);
        check("r1_csb_low_outside", low_out, 0);
        check("r1_op_sequence_errs", op_err, 0);
        check("r1_done_held", done, 1);

        // Run 2: stuck-at-1 on bit0 of word 5, start held through the run.
        fault_en = 1'b1;
        run_start(1'b1);
        wait_done("r2");
        check("r2_pass", pass, 0);
        check("r2_fail_count", fail_count, FAULT_FAILS);
        check("r2_ffa", first_fail_addr, 5);
        check("r2_ffe", first_fail_elem, 1);
        repeat (5) @(posedge clk0);
        #1;
        check("r2_single_run_low_cycles", low_in, OPS);
        check("r2_no_restart", low_out, 0);
        check("r2_done_held", done, 1);
        check("r2_busy_low", busy, 0);

        // Run 3: restart clears previous results.
        fault_en = 1'b0;
        run_start(1'b0);
        check("r3_S_done", done, 0);
        check("r3_S_fail_count", fail_count, 0);
        check("r3_S_ffa", first_fail_addr, 0);
        check("r3_S_ffe", first_fail_elem, 0);
        wait_done("r3");
        check("r3_pass", pass, 1);
        check("r3_fail_count", fail_count, 0);

        // Run 4: reset at S+50, then rerun.
        run_start(1'b0);
        repeat (49) @(posedge clk0);
        #1;
        rst0 = 1'b1;
        @(posedge clk0);
        #1;
        check_reset_state("midreset");
        rst0 = 1'b0;
        @(posedge clk0);
        #1;
        check("midreset_idle_fail_count", fail_count, 0);
        check("midreset_idle_csb0", sif.csb0, 1);
        run_start(1'b0);
        wait_done("r4");
        check("r4_pass", pass, 1);
        check("r4_fail_count", fail_count, 0);
        @(posedge clk0);
        #1;
        check("r4_csb_low_cycles", low_in, OPS);
        check("r4_op_sequence_errs", op_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
